// File: rtl/fetch_pkg.sv
// fetch_pkg: widths, aligner state encoding and helpers shared by the fetch aligner
package fetch_pkg;
  localparam int ADDRESS_WIDTH = 32;
  localparam int INSN_WIDTH = 99;
  localparam int BRANCH_BIT = 9;
  typedef enum logic {
    ALIGN_NORMAL = 1'b0,
    ALIGN_DSLOT = 1'b1
  } align_state_e;
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction
endpackage

// File: rtl/fetch_align_buffer_if.sv
// fetch_align_buffer_if: fetch-side inputs and issue-side outputs of the aligner
interface fetch_align_buffer_if #(
  parameter int ADDRESS_WIDTH = fetch_pkg::ADDRESS_WIDTH,
  parameter int INSN_WIDTH = fetch_pkg::INSN_WIDTH,
  parameter int FETCH_WIDTH = 4
);
  logic i_Flush;
  logic i_Stall;
  logic i_fetch_valid;
  logic o_fetch_ready;
  logic [ADDRESS_WIDTH-1:0] i_pc;
  logic [FETCH_WIDTH*INSN_WIDTH-1:0] i_isn;
  logic [FETCH_WIDTH-1:0] o_valid;
  logic [FETCH_WIDTH*INSN_WIDTH-1:0] o_isn;
  logic [FETCH_WIDTH*ADDRESS_WIDTH-1:0] o_pc;
  modport slave (
    input i_Flush, i_Stall, i_fetch_valid, i_pc, i_isn,
    output o_fetch_ready, o_valid, o_isn, o_pc
  );
  modport master (
    output i_Flush, i_Stall, i_fetch_valid, i_pc, i_isn,
    input o_fetch_ready, o_valid, o_isn, o_pc
  );
endinterface

// File: rtl/fetch_group_mask.sv
// fetch_group_mask: per-group keep mask from pc offset, branch flags and pending delay slot
module fetch_group_mask #(
  parameter int FETCH_WIDTH = 4,
  localparam int OW = fetch_pkg::clog2(FETCH_WIDTH)
) (
  input logic [OW-1:0] off,
  input logic [FETCH_WIDTH-1:0] br,
  input logic dslot,
  output logic [FETCH_WIDTH-1:0] keep,
  output logic [OW:0] kept,
  output logic dslot_next
);
  localparam int CW = OW + 1;
  logic pend;
  logic done;
  // pend marks a taken branch seen; the following kept slot is its delay slot
  always_comb begin
    keep = '0;
    kept = '0;
    pend = 1'b0;
    done = 1'b0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      keep[k] = dslot ? (OW'(k) == off) : (OW'(k) >= off && !done);
      if (keep[k] && !dslot) begin
        done = done | pend;
        pend = pend | br[k];
      end
      kept = kept + CW'(keep[k]);
    end
    dslot_next = pend && !done;
  end
endmodule

// File: rtl/fetch_align_buffer.sv
// fetch_align_buffer: trims fetch groups, compacts survivors into a ring and drains them in order
module fetch_align_buffer #(
  parameter int ADDRESS_WIDTH = fetch_pkg::ADDRESS_WIDTH,
  parameter int INSN_WIDTH = fetch_pkg::INSN_WIDTH,
  parameter int FETCH_WIDTH = 4,
  parameter int BUF_DEPTH = 16,
  parameter int BRANCH_BIT = fetch_pkg::BRANCH_BIT
) (
  input logic i_Clk,
  input logic i_Reset,
  fetch_align_buffer_if.slave bus
);
  import fetch_pkg::*;
  localparam int OW = clog2(FETCH_WIDTH);
  localparam int PW = clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  align_state_e state;
  align_state_e state_next;
  logic [INSN_WIDTH-1:0] isn_mem [BUF_DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_mem [BUF_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [CW-1:0] n;
  logic [FETCH_WIDTH-1:0] br;
  logic [FETCH_WIDTH-1:0] keep;
  logic [OW:0] kept;
  logic dslot_next;
  logic accept;
  logic [OW-1:0] acc;
  logic [OW-1:0] pos [FETCH_WIDTH];
  logic [ADDRESS_WIDTH-1:0] slot_pc [FETCH_WIDTH];
  logic unused;
  assign unused = ^bus.i_pc[1:0];
  always_comb begin
    br = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) br[k] = bus.i_isn[k*INSN_WIDTH + BRANCH_BIT];
  end
  fetch_group_mask #(.FETCH_WIDTH(FETCH_WIDTH)) u_mask (
    .off(bus.i_pc[OW+1:2]),
    .br(br),
    .dslot(state == ALIGN_DSLOT),
    .keep(keep),
    .kept(kept),
    .dslot_next(dslot_next)
  );
  assign bus.o_fetch_ready = count <= CW'(BUF_DEPTH - FETCH_WIDTH);
  assign accept = bus.i_fetch_valid & bus.o_fetch_ready & ~bus.i_Flush;
  assign n = bus.i_Stall ? '0 : (count > CW'(FETCH_WIDTH) ? CW'(FETCH_WIDTH) : count);
  assign count_next = count + (accept ? CW'(kept) : '0) - n;
  // pos[k] is the compacted ring offset of slot k among the kept slots
  always_comb begin
    acc = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      pos[k] = acc;
      acc = acc + OW'(keep[k]);
      slot_pc[k] = {bus.i_pc[ADDRESS_WIDTH-1:OW+2], OW'(k), 2'b00};
    end
  end
  always_comb begin
    state_next = state;
    if (bus.i_Flush) state_next = ALIGN_NORMAL;
    else if (accept) state_next = dslot_next ? ALIGN_DSLOT : ALIGN_NORMAL;
  end
  always_ff @(posedge i_Clk) begin
    state <= i_Reset ? ALIGN_NORMAL : state_next;
  end
  always_ff @(posedge i_Clk) begin
    if (accept)
      for (int k = 0; k < FETCH_WIDTH; k++)
        if (keep[k]) begin
          isn_mem[tail + PW'(pos[k])] <= bus.i_isn[k*INSN_WIDTH +: INSN_WIDTH];
          pc_mem[tail + PW'(pos[k])] <= slot_pc[k];
        end
  end
  always_ff @(posedge i_Clk) begin
    if (i_Reset || bus.i_Flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      bus.o_valid <= '0;
      bus.o_isn <= '0;
      bus.o_pc <= '0;
    end else begin
      if (accept) tail <= tail + PW'(kept);
      head <= head + PW'(n);
      count <= count_next;
      if (!bus.i_Stall)
        for (int j = 0; j < FETCH_WIDTH; j++) begin
          bus.o_valid[j] <= CW'(j) < n;
          bus.o_isn[j*INSN_WIDTH +: INSN_WIDTH] <= CW'(j) < n ? isn_mem[head + PW'(j)] : '0;
          bus.o_pc[j*ADDRESS_WIDTH +: ADDRESS_WIDTH] <= CW'(j) < n ? pc_mem[head + PW'(j)] : '0;
        end
    end
  end
endmodule

// File: tb/tb_fetch_align_buffer.sv
// tb_fetch_align_buffer: directed cycle tables with hand-computed outputs for the fetch aligner
module tb_fetch_align_buffer;
  localparam int AW = 32;
  localparam int IW = 99;
  localparam int FW = 4;
  localparam int BD = 16;
  typedef struct packed {
    logic v;
    logic [31:0] pc;
    logic [3:0] br;
    logic st;
    logic fl;
    logic rs;
    logic [2:0] nv;
    logic [31:0] base;
    logic rdy;
  } row_t;
  logic clk;
  logic rst;
  int checks;
  int failures;
  logic [IW-1:0] isn_of [int unsigned];
  fetch_align_buffer_if #(.ADDRESS_WIDTH(AW), .INSN_WIDTH(IW), .FETCH_WIDTH(FW)) bus ();
  fetch_align_buffer #(
    .ADDRESS_WIDTH(AW), .INSN_WIDTH(IW), .FETCH_WIDTH(FW), .BUF_DEPTH(BD), .BRANCH_BIT(9)
  ) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic row_t r(int v, int pc, int br, int st, int fl, int rs, int nv, int base, int rdy);
    row_t t;
    t.v = v[0];
    t.pc = pc;
    t.br = br[3:0];
    t.st = st[0];
    t.fl = fl[0];
    t.rs = rs[0];
    t.nv = nv[2:0];
    t.base = base;
    t.rdy = rdy[0];
    return t;
  endfunction
  function automatic logic [IW-1:0] slot_isn(logic [AW-1:0] pc, logic b);
    return IW'({pc, 16'hA5A5}) | (IW'(b) << 9) | (IW'(1) << (IW - 1));
  endfunction
  function automatic logic [FW-1:0] therm(logic [2:0] nv);
    return FW'((1 << nv) - 1);
  endfunction
  function automatic logic [FW*AW-1:0] exp_pc(row_t t);
    logic [FW*AW-1:0] v;
    v = '0;
    for (int k = 0; k < FW; k++) if (k < int'(t.nv)) v[k*AW +: AW] = t.base + 32'(4 * k);
    return v;
  endfunction
  function automatic logic [FW*IW-1:0] exp_isn(row_t t);
    logic [FW*IW-1:0] v;
    v = '0;
    for (int k = 0; k < FW; k++) if (k < int'(t.nv)) v[k*IW +: IW] = isn_of[t.base + 32'(4 * k)];
    return v;
  endfunction
  task automatic drive(row_t t);
    logic [FW*IW-1:0] g;
    logic [AW-1:0] p;
    for (int k = 0; k < FW; k++) begin
      p = {t.pc[31:4], 2'(k), 2'b00};
      g[k*IW +: IW] = slot_isn(p, t.br[k]);
      if (t.v) isn_of[p] = g[k*IW +: IW];
    end
    rst = t.rs;
    bus.i_fetch_valid = t.v;
    bus.i_pc = t.pc;
    bus.i_isn = g;
    bus.i_Stall = t.st;
    bus.i_Flush = t.fl;
  endtask
  task automatic test_reset();
    row_t t[$];
    t = '{r(1, 'h900, 0, 0, 0, 1, 0, 0, 1), r(1, 'h910, 0, 0, 1, 1, 0, 0, 1), r(0, 0, 0, 0, 0, 0, 0, 0, 1)};
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      checks += 4;
      if (bus.o_valid !== therm(t[i].nv)) begin failures++; $display("FAIL reset[%0d] o_valid got %b want %b", i, bus.o_valid, therm(t[i].nv)); end
      if (bus.o_pc !== exp_pc(t[i])) begin failures++; $display("FAIL reset[%0d] o_pc got %h want %h", i, bus.o_pc, exp_pc(t[i])); end
      if (bus.o_isn !== exp_isn(t[i])) begin failures++; $display("FAIL reset[%0d] o_isn got %h want %h", i, bus.o_isn, exp_isn(t[i])); end
      if (bus.o_fetch_ready !== t[i].rdy) begin failures++; $display("FAIL reset[%0d] ready got %b want %b", i, bus.o_fetch_ready, t[i].rdy); end
    end
  endtask
  task automatic test_full_group();
    row_t t[$];
    t = '{r(1, 'h100, 0, 0, 0, 0, 0, 0, 1), r(0, 0, 0, 0, 0, 0, 4, 'h100, 1), r(0, 0, 0, 0, 0, 0, 0, 0, 1)};
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      checks += 4;
      if (bus.o_valid !== therm(t[i].nv)) begin failures++; $display("FAIL full[%0d] o_valid got %b want %b", i, bus.o_valid, therm(t[i].nv)); end
      if (bus.o_pc !== exp_pc(t[i])) begin failures++; $display("FAIL full[%0d] o_pc got %h want %h", i, bus.o_pc, exp_pc(t[i])); end
      if (bus.o_isn !== exp_isn(t[i])) begin failures++; $display("FAIL full[%0d] o_isn got %h want %h", i, bus.o_isn, exp_isn(t[i])); end
      if (bus.o_fetch_ready !== t[i].rdy) begin failures++; $display("FAIL full[%0d] ready got %b want %b", i, bus.o_fetch_ready, t[i].rdy); end
    end
  endtask
  task automatic test_offset();
    row_t t[$];
    t = '{r(1, 'h108, 0, 0, 0, 0, 0, 0, 1), r(1, 'h110, 0, 0, 0, 0, 2, 'h108, 1),
          r(0, 0, 0, 0, 0, 0, 4, 'h110, 1), r(0, 0, 0, 0, 0, 0, 0, 0, 1)};
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      checks += 4;
      if (bus.o_valid !== therm(t[i].nv)) begin failures++; $display("FAIL offset[%0d] o_valid got %b want %b", i, bus.o_valid, therm(t[i].nv)); end
      if (bus.o_pc !== exp_pc(t[i])) begin failures++; $display("FAIL offset[%0d] o_pc got %h want %h", i, bus.o_pc, exp_pc(t[i])); end
      if (bus.o_isn !== exp_isn(t[i])) begin failures++; $display("FAIL offset[%0d] o_isn got %h want %h", i, bus.o_isn, exp_isn(t[i])); end
      if (bus.o_fetch_ready !== t[i].rdy) begin failures++; $display("FAIL offset[%0d] ready got %b want %b", i, bus.o_fetch_ready, t[i].rdy); end
    end
  endtask
  task automatic test_branch();
    row_t t[$];
    t = '{r(1, 'h200, 'b0010, 0, 0, 0, 0, 0, 1), r(0, 0, 0, 0, 0, 0, 3, 'h200, 1), r(0, 0, 0, 0, 0, 0, 0, 0, 1)};
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      checks += 4;
      if (bus.o_valid !== therm(t[i].nv)) begin failures++; $display("FAIL branch[%0d] o_valid got %b want %b", i, bus.o_valid, therm(t[i].nv)); end
      if (bus.o_pc !== exp_pc(t[i])) begin failures++; $display("FAIL branch[%0d] o_pc got %h want %h", i, bus.o_pc, exp_pc(t[i])); end
      if (bus.o_isn !== exp_isn(t[i])) begin failures++; $display("FAIL branch[%0d] o_isn got %h want %h", i, bus.o_isn, exp_isn(t[i])); end
      if (bus.o_fetch_ready !== t[i].rdy) begin failures++; $display("FAIL branch[%0d] ready got %b want %b", i, bus.o_fetch_ready, t[i].rdy); end
    end
  endtask
  task automatic test_dslot();
    row_t t[$];
    t = '{r(1, 'h300, 'b1000, 0, 0, 0, 0, 0, 1), r(1, 'h310, 'b0001, 0, 0, 0, 4, 'h300, 1),
          r(1, 'h320, 0, 0, 0, 0, 1, 'h310, 1), r(0, 0, 0, 0, 0, 0, 4, 'h320, 1), r(0, 0, 0, 0, 0, 0, 0, 0, 1)};
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      checks += 4;
      if (bus.o_valid !== therm(t[i].nv)) begin failures++; $display("FAIL dslot[%0d] o_valid got %b want %b", i, bus.o_valid, therm(t[i].nv)); end
      if (bus.o_pc !== exp_pc(t[i])) begin failures++; $display("FAIL dslot[%0d] o_pc got %h want %h", i, bus.o_pc, exp_pc(t[i])); end
      if (bus.o_isn !== exp_isn(t[i])) begin failures++; $display("FAIL dslot[%0d] o_isn got %h want %h", i, bus.o_isn, exp_isn(t[i])); end
      if (bus.o_fetch_ready !== t[i].rdy) begin failures++; $display("FAIL dslot[%0d] ready got %b want %b", i, bus.o_fetch_ready, t[i].rdy); end
    end
  endtask
  task automatic test_stall_wrap();
    row_t t[$];
    t = '{r(1, 'h400, 0, 0, 0, 0, 0, 0, 1), r(1, 'h410, 0, 0, 0, 0, 4, 'h400, 1),
          r(1, 'h420, 0, 1, 0, 0, 4, 'h400, 1), r(1, 'h430, 0, 1, 0, 0, 4, 'h400, 1),
          r(1, 'h440, 0, 1, 0, 0, 4, 'h400, 0), r(1, 'h450, 0, 1, 0, 0, 4, 'h400, 0),
          r(0, 0, 0, 0, 0, 0, 4, 'h410, 1), r(0, 0, 0, 0, 0, 0, 4, 'h420, 1),
          r(0, 0, 0, 0, 0, 0, 4, 'h430, 1), r(0, 0, 0, 0, 0, 0, 4, 'h440, 1), r(0, 0, 0, 0, 0, 0, 0, 0, 1)};
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      checks += 4;
      if (bus.o_valid !== therm(t[i].nv)) begin failures++; $display("FAIL stall[%0d] o_valid got %b want %b", i, bus.o_valid, therm(t[i].nv)); end
      if (bus.o_pc !== exp_pc(t[i])) begin failures++; $display("FAIL stall[%0d] o_pc got %h want %h", i, bus.o_pc, exp_pc(t[i])); end
      if (bus.o_isn !== exp_isn(t[i])) begin failures++; $display("FAIL stall[%0d] o_isn got %h want %h", i, bus.o_isn, exp_isn(t[i])); end
      if (bus.o_fetch_ready !== t[i].rdy) begin failures++; $display("FAIL stall[%0d] ready got %b want %b", i, bus.o_fetch_ready, t[i].rdy); end
    end
  endtask
  task automatic test_flush();
    row_t t[$];
    t = '{r(1, 'h4F0, 0, 0, 0, 0, 0, 0, 1), r(1, 'h500, 0, 0, 0, 0, 4, 'h4F0, 1),
          r(1, 'h510, 0, 1, 0, 0, 4, 'h4F0, 1), r(1, 'h528, 'b1000, 1, 0, 0, 4, 'h4F0, 1),
          r(1, 'h600, 0, 1, 1, 0, 0, 0, 1), r(0, 0, 0, 0, 0, 0, 0, 0, 1),
          r(1, 'h700, 0, 0, 0, 0, 0, 0, 1), r(0, 0, 0, 0, 0, 0, 4, 'h700, 1), r(0, 0, 0, 0, 0, 0, 0, 0, 1)};
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      checks += 4;
      if (bus.o_valid !== therm(t[i].nv)) begin failures++; $display("FAIL flush[%0d] o_valid got %b want %b", i, bus.o_valid, therm(t[i].nv)); end
      if (bus.o_pc !== exp_pc(t[i])) begin failures++; $display("FAIL flush[%0d] o_pc got %h want %h", i, bus.o_pc, exp_pc(t[i])); end
      if (bus.o_isn !== exp_isn(t[i])) begin failures++; $display("FAIL flush[%0d] o_isn got %h want %h", i, bus.o_isn, exp_isn(t[i])); end
      if (bus.o_fetch_ready !== t[i].rdy) begin failures++; $display("FAIL flush[%0d] ready got %b want %b", i, bus.o_fetch_ready, t[i].rdy); end
    end
  endtask
  task automatic test_reset_mid_drain();
    row_t t[$];
    t = '{r(1, 'h800, 0, 0, 0, 0, 0, 0, 1), r(1, 'h810, 0, 0, 0, 0, 4, 'h800, 1),
          r(1, 'h820, 0, 0, 0, 1, 0, 0, 1), r(0, 0, 0, 0, 0, 0, 0, 0, 1), r(0, 0, 0, 0, 0, 0, 0, 0, 1)};
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      checks += 4;
      if (bus.o_valid !== therm(t[i].nv)) begin failures++; $display("FAIL rstmid[%0d] o_valid got %b want %b", i, bus.o_valid, therm(t[i].nv)); end
      if (bus.o_pc !== exp_pc(t[i])) begin failures++; $display("FAIL rstmid[%0d] o_pc got %h want %h", i, bus.o_pc, exp_pc(t[i])); end
      if (bus.o_isn !== exp_isn(t[i])) begin failures++; $display("FAIL rstmid[%0d] o_isn got %h want %h", i, bus.o_isn, exp_isn(t[i])); end
      if (bus.o_fetch_ready !== t[i].rdy) begin failures++; $display("FAIL rstmid[%0d] ready got %b want %b", i, bus.o_fetch_ready, t[i].rdy); end
    end
  endtask
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.i_Flush = 1'b0;
    bus.i_Stall = 1'b0;
    bus.i_fetch_valid = 1'b0;
    bus.i_pc = '0;
    bus.i_isn = '0;
    @(negedge clk);
    test_reset();
    test_full_group();
    test_offset();
    test_branch();
    test_dslot();
    test_stall_wrap();
    test_flush();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
- Parametrised successor to the 4-wide fetch aligner. Sits between decoder and issue queues.
- Each fetch group holds FETCH_WIDTH instructions. Per group it drops the slots before the PC offset and the slots after a branch's delay slot.
- Delay slots that cross a group boundary are tracked across groups.
- Surviving instructions are compacted into a circular buffer and drained in order, up to FETCH_WIDTH per cycle, into registered outputs. Supports stall and flush.

Parameters:
- ADDRESS_WIDTH, 32, PC width.
- INSN_WIDTH, 99, decoded instruction width.
- FETCH_WIDTH, 4, instructions per fetch group; must be a power of two, ≥2.
- BUF_DEPTH, 16, buffer entries; must be a power of two, ≥2*FETCH_WIDTH.
- BRANCH_BIT, 9, bit index of the branch flag inside a decoded instruction.

Ports:
- i_Clk  in  1  clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Flush  in  1  discard all buffered and pending state (redirect).
- i_Stall  in  1  downstream cannot accept; outputs hold.
- i_fetch_valid  in  1  fetch group present this cycle.
- o_fetch_ready  out  1  group will be accepted if valid.
- i_pc  in  ADDRESS_WIDTH  PC of the group's addressed instruction.
- i_isn  in  FETCH_WIDTH*INSN_WIDTH  slot k at bits [k*INSN_WIDTH +: INSN_WIDTH].
- o_valid  out  FETCH_WIDTH  thermometer mask of valid output slots, slot 0 = LSB.
- o_isn  out  FETCH_WIDTH*INSN_WIDTH  aligned instructions; invalid slots are zero.
- o_pc  out  FETCH_WIDTH*ADDRESS_WIDTH  PC of each output slot; invalid slots are zero.

Behaviour:
- Clock and reset: one clock, i_Clk. Reset i_Reset is synchronous and active-high.
- Reset values: o_valid=0, o_isn=0, o_pc=0, buffer empty, state=NORMAL. o_fetch_ready is high in the cycle after reset.
- Offset: off = i_pc[log2(FETCH_WIDTH)+1:2]. Slots below off are invalid. Slot k has PC {i_pc[ADDRESS_WIDTH-1:log2(FETCH_WIDTH)+2], k[...], 2'b00}.
- Branch truncation: b is the lowest slot ≥off with isn[BRANCH_BIT]=1.
  - If b < FETCH_WIDTH-1: keep slots off..b+1 and drop the rest.
  - If b = FETCH_WIDTH-1: keep off..b and move state to DSLOT_PENDING.
  - No branch: keep off..FETCH_WIDTH-1.
- DSLOT_PENDING: the next accepted group keeps only its slot at off, regardless of that slot's branch bit (a branch in a delay slot is not re-truncated). State then returns to NORMAL.
- Acceptance:
  - o_fetch_ready = (free entries ≥ FETCH_WIDTH), computed from registered count. It is combinational from state only and never depends on i_fetch_valid.
  - A group is accepted on an edge where i_fetch_valid & o_fetch_ready & ~i_Flush.
  - Kept slots are written compacted at tail, in slot order. Tail advances by the kept count, modulo BUF_DEPTH.
- Drain, on each edge with ~i_Stall:
  - n = min(count, FETCH_WIDTH) entries move from head into o_isn/o_pc slots 0..n-1.
  - o_valid gets n ones from the LSB; head advances by n, wrapping.
  - Entries written on the same edge are not visible until the next edge. Minimum latency is accept edge E to outputs valid after edge E+1.
- Stall: when i_Stall=1, o_* hold and nothing drains. Enqueue continues while o_fetch_ready=1.
- Simultaneous enqueue and drain: count_next = count + kept − n. No overflow is possible by construction.
- Flush: on the edge with i_Flush=1, buffer empties, state=NORMAL, o_valid=0. Any input group that cycle is ignored. Flush has priority over stall and enqueue.
- Reset has priority over flush. Reset mid-drain clears everything in one edge.
- Wrap-around: pointers are log2(BUF_DEPTH) bits. Full versus empty is resolved by count, which is log2(BUF_DEPTH)+1 bits.

Decomposition:
- Shared package fetch_pkg holds:
  - INSN_WIDTH, ADDRESS_WIDTH, BRANCH_BIT;
  - state encoding ALIGN_NORMAL=1'b0, ALIGN_DSLOT=1'b1;
  - a function clog2.
- One sub-module, fetch_group_mask. It is combinational: it takes pc offset, branch bits and the dslot flag, and returns the keep mask, kept count and dslot_next.
- The top level holds the buffer, pointers, count and output registers.

Test Plan:
- FETCH_WIDTH=4, pc=0x100, no branches, i_Stall=0 → after E+1: o_valid=4'b1111, o_pc=0x100,0x104,0x108,0x10C.
- pc=0x108 (off=2), no branches → 2 entries buffered, o_valid=4'b0011, o_pc slot0=0x108. The next group at 0x110 then fills the remaining slots in order.
- pc=0x200, branch in slot 1 → kept slots 0,1,2, o_valid=4'b0111. Slot 3 is never output.
- Branch in slot 3 of group 0x300, then group 0x310 with its slot 0 a branch → outputs 0x300..0x30C and then 0x310 only. State returns to NORMAL; group 0x320 is fully kept.
- Hold i_Stall=1 while feeding groups → o_fetch_ready falls when count>BUF_DEPTH-4 and outputs hold. Release → in-order drain of 4 per cycle with no loss or duplication, including across pointer wrap.
- Buffer holding 10 entries, i_Flush=1 together with i_fetch_valid=1 → next cycle o_valid=0, count=0, o_fetch_ready=1. A pending DSLOT state is also cleared.
